// File: rtl/arcade_cfg_loader_if.sv
// arcade_cfg_loader_if: hps_io ioctl download stream
interface arcade_cfg_loader_if #(parameter int ADDR_W = 25);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  modport master (output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/arcade_cfg_loader.sv
// arcade_cfg_loader: captures mod byte and DIP bank from ioctl, sequences core reset
module arcade_cfg_loader #(
  parameter int DIP_BYTES   = 8,
  parameter int NUM_MODS    = 32,
  parameter int MOD_INDEX   = 1,
  parameter int DIP_INDEX   = 254,
  parameter int ROM_INDEX   = 0,
  parameter int HOLD_CYCLES = 256,
  parameter int ADDR_W      = 25
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  arcade_cfg_loader_if.slave     io,
  output logic [8*DIP_BYTES-1:0] dip_bank,
  output logic                   dip_valid,
  output logic [7:0]             mod_id,
  output logic [NUM_MODS-1:0]    mod_onehot,
  output logic                   mod_valid,
  output logic                   core_reset,
  output logic                   cfg_changed
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {RUN, LOAD, HOLD} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          dl_prev, dip_seen, mod_seen;
  logic [7:0]    idx_prev;
  logic          accept, mod_wr, dip_wr, rise, fall, load_rise, mod_chg, mod_in_range;
  assign accept       = io.ioctl_wr & io.ioctl_download;
  assign mod_wr       = accept && io.ioctl_index == 8'(MOD_INDEX) && io.ioctl_addr == '0;
  assign dip_wr       = accept && io.ioctl_index == 8'(DIP_INDEX) && io.ioctl_addr < ADDR_W'(DIP_BYTES);
  assign rise         = io.ioctl_download & ~dl_prev;
  assign fall         = ~io.ioctl_download & dl_prev;
  assign load_rise    = rise && (io.ioctl_index == 8'(ROM_INDEX) || io.ioctl_index == 8'(MOD_INDEX));
  assign mod_chg      = mod_wr && io.ioctl_dout != mod_id;
  assign mod_in_range = {24'd0, mod_id} < 32'(NUM_MODS);
  // download edge history; index kept alongside so a fall knows which download ended
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_prev  <= 1'b0;
      idx_prev <= 8'd0;
    end else begin
      dl_prev  <= io.ioctl_download;
      idx_prev <= io.ioctl_index;
    end
  end
  // DIP bytes land by address; valid once a download that wrote something ends
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dip_bank  <= '0;
      dip_seen  <= 1'b0;
      dip_valid <= 1'b0;
    end else begin
      if (rise) dip_seen <= 1'b0;
      if (dip_wr) dip_seen <= 1'b1;
      if (fall && idx_prev == 8'(DIP_INDEX) && dip_seen) dip_valid <= 1'b1;
      for (int k = 0; k < DIP_BYTES; k++)
        if (dip_wr && io.ioctl_addr == ADDR_W'(k)) dip_bank[8*k +: 8] <= io.ioctl_dout;
    end
  end
  // mod byte capture, then a second stage decodes it so the decode never sees a half-written value
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mod_id     <= 8'd0;
      mod_seen   <= 1'b0;
      mod_onehot <= NUM_MODS'(1);
      mod_valid  <= 1'b0;
    end else begin
      if (mod_wr) begin
        mod_id   <= io.ioctl_dout;
        mod_seen <= 1'b1;
      end
      mod_onehot <= mod_in_range ? NUM_MODS'(1) << mod_id : '0;
      mod_valid  <= mod_seen & mod_in_range;
    end
  end
  // reset sequencer: hold the core in reset during ROM/mod loads and for a hold-off afterwards
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= HOLD;
      cnt         <= HOLD_INIT;
      core_reset  <= 1'b1;
      cfg_changed <= 1'b0;
    end else begin
      cfg_changed <= 1'b0;
      case (state)
        RUN:
          if (load_rise) begin
            state      <= LOAD;
            core_reset <= 1'b1;
          end else if (mod_chg) begin
            state      <= HOLD;
            cnt        <= HOLD_INIT;
            core_reset <= 1'b1;
          end
        LOAD:
          if (fall) begin
            state <= HOLD;
            cnt   <= HOLD_INIT;
          end
        HOLD:
          if (load_rise) state <= LOAD;
          else if (mod_chg) cnt <= HOLD_INIT;
          else if (cnt == '0) begin
            state       <= RUN;
            core_reset  <= 1'b0;
            cfg_changed <= 1'b1;
          end else cnt <= cnt - 1'b1;
        default: begin
          state      <= HOLD;
          cnt        <= HOLD_INIT;
          core_reset <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arcade_cfg_loader.sv
// tb_arcade_cfg_loader: table-driven check of capture, decode and reset sequencing
module tb_arcade_cfg_loader;
  localparam int HC = 4;
  localparam logic [63:0] D = 64'hFF00_0000_0000_55AA;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] dip_bank;
  logic        dip_valid;
  logic [7:0]  mod_id;
  logic [31:0] mod_onehot;
  logic        mod_valid, core_reset, cfg_changed;
  int          checks = 0;
  int          errors = 0;
  arcade_cfg_loader_if #(.ADDR_W(25)) io();
  arcade_cfg_loader #(.HOLD_CYCLES(HC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .io(io),
    .dip_bank(dip_bank), .dip_valid(dip_valid), .mod_id(mod_id), .mod_onehot(mod_onehot),
    .mod_valid(mod_valid), .core_reset(core_reset), .cfg_changed(cfg_changed)
  );
  always #5 clk_sys = ~clk_sys;
  typedef struct {
    logic        rn, dl, wr;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        cr, cc;
    logic [7:0]  mid;
    logic [31:0] oh;
    logic        mv;
    logic [63:0] dip;
    logic        dv;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(input int rn, dl, wr, idx, addr, dout, cr, cc, mid, oh, mv,
                             input logic [63:0] dip, input int dv);
    vec_t r;
    r.rn = rn[0]; r.dl = dl[0]; r.wr = wr[0]; r.idx = 8'(idx); r.addr = 25'(addr); r.dout = 8'(dout);
    r.cr = cr[0]; r.cc = cc[0]; r.mid = 8'(mid); r.oh = 32'(oh); r.mv = mv[0]; r.dip = dip; r.dv = dv[0];
    return r;
  endfunction
  task automatic apply(input int rn, dl, wr, idx, addr, dout);
    reset_n           = rn[0];
    io.ioctl_download = dl[0];
    io.ioctl_wr       = wr[0];
    io.ioctl_index    = 8'(idx);
    io.ioctl_addr     = 25'(addr);
    io.ioctl_dout     = 8'(dout);
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  initial begin
    int n;
    // reset, then release: hold-off runs out and cfg_changed pulses
    tv.push_back(v(0,0,0,0,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(0,0,0,0,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,       0,1,0,1,0,0,0));
    tv.push_back(v(1,0,0,0,0,0,       0,0,0,1,0,0,0));
    // mod download: addr0 taken, addr1 ignored, decode one cycle later
    tv.push_back(v(1,1,0,1,0,0,       1,0,0,1,0,0,0));
    tv.push_back(v(1,1,1,1,0,'h05,    1,0,5,1,0,0,0));
    tv.push_back(v(1,1,1,1,1,'h09,    1,0,5,'h20,1,0,0));
    tv.push_back(v(1,1,0,1,0,0,       1,0,5,'h20,1,0,0));
    tv.push_back(v(1,0,0,1,0,0,       1,0,5,'h20,1,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,5,'h20,1,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,5,'h20,1,0,0));
    tv.push_back(v(1,0,0,0,0,0,       1,0,5,'h20,1,0,0));
    tv.push_back(v(1,0,0,0,0,0,       0,1,5,'h20,1,0,0));
    // DIP download: bytes 0,1,7 kept, addr 8 dropped, valid after fall, no core reset
    tv.push_back(v(1,1,0,254,0,0,     0,0,5,'h20,1,0,0));
    tv.push_back(v(1,1,1,254,0,'hAA,  0,0,5,'h20,1,64'hAA,0));
    tv.push_back(v(1,1,1,254,1,'h55,  0,0,5,'h20,1,64'h55AA,0));
    tv.push_back(v(1,1,1,254,7,'hFF,  0,0,5,'h20,1,D,0));
    tv.push_back(v(1,1,1,254,8,'h12,  0,0,5,'h20,1,D,0));
    tv.push_back(v(1,0,0,254,0,0,     0,0,5,'h20,1,D,1));
    tv.push_back(v(1,0,0,0,0,0,       0,0,5,'h20,1,D,1));
    // unlisted index download held open, then switched to mod index without a new rise
    tv.push_back(v(1,1,0,'h10,0,0,    0,0,5,'h20,1,D,1));
    tv.push_back(v(1,1,1,'h10,0,'h33, 0,0,5,'h20,1,D,1));
    tv.push_back(v(1,1,1,1,0,'h05,    0,0,5,'h20,1,D,1));
    tv.push_back(v(1,1,0,1,0,0,       0,0,5,'h20,1,D,1));
    tv.push_back(v(1,1,1,1,0,'h0C,    1,0,'h0C,'h20,1,D,1));
    tv.push_back(v(1,1,0,1,0,0,       1,0,'h0C,'h1000,1,D,1));
    tv.push_back(v(1,1,0,1,0,0,       1,0,'h0C,'h1000,1,D,1));
    tv.push_back(v(1,1,0,1,0,0,       1,0,'h0C,'h1000,1,D,1));
    tv.push_back(v(1,1,0,1,0,0,       0,1,'h0C,'h1000,1,D,1));
    tv.push_back(v(1,1,1,1,0,'h40,    1,0,'h40,'h1000,1,D,1));
    tv.push_back(v(1,0,0,1,0,0,       1,0,'h40,0,0,D,1));
    // ROM rise with hold counter at 2: back to LOAD, ROM strobes touch nothing
    tv.push_back(v(1,1,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,1,1,0,0,'h99,    1,0,'h40,0,0,D,1));
    tv.push_back(v(1,1,1,0,1,'h77,    1,0,'h40,0,0,D,1));
    tv.push_back(v(1,1,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       1,0,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       0,1,'h40,0,0,D,1));
    tv.push_back(v(1,0,0,0,0,0,       0,0,'h40,0,0,D,1));
    foreach (tv[i]) begin
      apply(int'(tv[i].rn), int'(tv[i].dl), int'(tv[i].wr), int'(tv[i].idx), int'(tv[i].addr), int'(tv[i].dout));
      tick();
      chk("core_reset",  i, 64'(core_reset),  64'(tv[i].cr));
      chk("cfg_changed", i, 64'(cfg_changed), 64'(tv[i].cc));
      chk("mod_id",      i, 64'(mod_id),      64'(tv[i].mid));
      chk("mod_onehot",  i, 64'(mod_onehot),  64'(tv[i].oh));
      chk("mod_valid",   i, 64'(mod_valid),   64'(tv[i].mv));
      chk("dip_bank",    i, dip_bank,         tv[i].dip);
      chk("dip_valid",   i, 64'(dip_valid),   64'(tv[i].dv));
    end
    // reset asserted mid-LOAD together with a DIP write: everything back to reset values
    apply(1,1,0,0,0,0);
    tick();
    chk("t6_load", 100, 64'(core_reset), 64'd1);
    apply(0,1,1,254,0,'h77);
    tick();
    chk("t6_dip_bank",   101, dip_bank,          64'd0);
    chk("t6_dip_valid",  101, 64'(dip_valid),    64'd0);
    chk("t6_mod_id",     101, 64'(mod_id),       64'd0);
    chk("t6_mod_onehot", 101, 64'(mod_onehot),   64'd1);
    chk("t6_mod_valid",  101, 64'(mod_valid),    64'd0);
    chk("t6_core_reset", 101, 64'(core_reset),   64'd1);
    chk("t6_cfg_chg",    101, 64'(cfg_changed),  64'd0);
    apply(0,0,0,0,0,0);
    tick();
    apply(1,0,0,0,0,0);
    n = 0;
    do begin
      tick();
      n++;
    end while (core_reset !== 1'b0 && n < 20);
    chk("t6_hold_len",  102, 64'(n),           64'(HC));
    chk("t6_cfg_pulse", 102, 64'(cfg_changed), 64'd1);
    tick();
    chk("t6_cfg_end",   103, 64'(cfg_changed), 64'd0);
    chk("t6_dip_kept",  103, dip_bank,         64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arcade_cfg_loader.md
Name: arcade_cfg_loader

Overview:
- Parametrised configuration front-end between hps_io and an arcade core.
- Captures the game-select (mod) byte and a DIP bank of configurable depth from ioctl streams.
- Decodes the mod byte to a registered one-hot vector with a validity flag.
- Sequences a core reset that covers ROM/mod downloads and mod changes, followed by a programmable hold-off.

Parameters:
- DIP_BYTES, 8, number of DIP bytes captured (1..32).
- NUM_MODS, 32, width of the one-hot mod vector (1..256).
- MOD_INDEX, 1, ioctl_index carrying the mod byte.
- DIP_INDEX, 254, ioctl_index carrying DIP bytes.
- ROM_INDEX, 0, ioctl_index carrying ROM data.
- HOLD_CYCLES, 256, clk_sys cycles core_reset stays high after a download or mod change (>=1).
- ADDR_W, 25, ioctl_addr width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte write strobe (one cycle).
- ioctl_index  in  8  download target index.
- ioctl_addr  in  ADDR_W  byte address within the download.
- ioctl_dout  in  8  download data byte.
- dip_bank  out  8*DIP_BYTES  DIP byte k at bits [8k+7:8k].
- dip_valid  out  1  at least one complete DIP download has occurred.
- mod_id  out  8  last accepted mod byte.
- mod_onehot  out  NUM_MODS  one-hot decode of mod_id.
- mod_valid  out  1  a mod byte has been accepted and mod_id < NUM_MODS.
- core_reset  out  1  active-high reset request to the core.
- cfg_changed  out  1  single-cycle pulse when core_reset deasserts.

Behaviour:
- Writes are accepted only when ioctl_wr=1 and ioctl_download=1. A strobe while download=0 is ignored.
- Reset values (reset_n=0 at a clock edge; reset_n wins over all simultaneous events):
  - dip_bank all 0, dip_valid 0.
  - mod_id 0, mod_onehot bit0=1 and all other bits 0, mod_valid 0.
  - core_reset 1, cfg_changed 0.
  - FSM in HOLD with counter=HOLD_CYCLES-1.
- Mod capture:
  - Accept only when index==MOD_INDEX and ioctl_addr==0. Bytes at other addresses are ignored.
  - mod_id updates 1 cycle after the strobe.
  - mod_onehot and mod_valid update 1 cycle after mod_id (2 cycles after the strobe).
  - mod_id>=NUM_MODS gives mod_onehot all 0 and mod_valid 0.
- DIP capture:
  - Accept when index==DIP_INDEX and ioctl_addr<DIP_BYTES; byte k = ioctl_addr. Addresses >= DIP_BYTES are ignored.
  - dip_bank updates 1 cycle after the strobe. Bytes not rewritten keep their previous value.
  - dip_valid is set on the falling edge of ioctl_download when the index is DIP_INDEX and at least one byte was accepted during that download. It is cleared only by reset.
  - DIP downloads never assert core_reset.
- Edge detection: ioctl_download is registered once. rise = cur & ~prev; fall = ~cur & prev. Index is sampled at the same edge.
- Reset FSM, states RUN, LOAD, HOLD:
  - RUN: core_reset=0.
    - rise with index ROM_INDEX or MOD_INDEX goes to LOAD.
    - An accepted mod write whose value differs from the current mod_id goes to HOLD with counter=HOLD_CYCLES-1.
  - LOAD: core_reset=1. Remain until fall, then go to HOLD with counter=HOLD_CYCLES-1.
  - HOLD: core_reset=1; the counter decrements each cycle.
    - A qualifying rise returns to LOAD; this takes priority over the counter.
    - A differing mod write reloads the counter.
    - With the counter at 0 and no event, go to RUN.
  - core_reset is a registered output that equals (state!=RUN) for the next state.
    - core_reset falls exactly HOLD_CYCLES cycles after the cycle in which fall is detected.
    - cfg_changed pulses high for the single cycle in which core_reset first reads 0.
  - Counter width is clog2(HOLD_CYCLES+1). It must not wrap below 0.
- A download of an unlisted index (for example a hiscore index) has no effect on any output.

Test Plan:
1. Reset, HOLD_CYCLES=4, then release reset_n. core_reset must stay 1 for 4 cycles and then drop; cfg_changed pulses once; mod_onehot=1, mod_valid=0.
2. MOD_INDEX download, addr0=0x05, addr1=0x09. mod_id=0x05 one cycle after the first strobe; mod_onehot=0x20 and mod_valid=1 two cycles after. core_reset is high from rise until 4 cycles after fall.
3. DIP_INDEX download of bytes 0xAA,0x55,…,0xFF at addr 0..8 with DIP_BYTES=8. dip_bank[7:0]=0xAA, dip_bank[15:8]=0x55, and the addr-8 byte is ignored. dip_valid goes to 1 one cycle after fall; core_reset stays 0 throughout.
4. In RUN, rewrite mod 0x05 with the same value: no core_reset. Then write mod 0x0C: core_reset=1 for 4 cycles. A value ≥ NUM_MODS (0x40 with NUM_MODS=32) gives mod_onehot=0 and mod_valid=0.
5. ROM download rise during HOLD with counter=2: the FSM must enter LOAD, and core_reset stays high through fall plus 4 cycles. A ROM download with ioctl_wr strobes changes neither dip_bank nor mod_id.
6. Assert reset_n=0 mid-LOAD with a simultaneous DIP write. All outputs return to reset values and the write is dropped.
